// File: rtl/pipe_wb_regfile_pkg.sv
// Shared pipeline constants for the writeback / register-file slice.
// Holds the forwarding-select encodings and the register-file geometry.
package pipe_wb_regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [REG_AW-1:0] R0 = 5'd0;

  typedef enum logic [1:0] {
    FWD_REG  = 2'd0,
    FWD_EALU = 2'd1,
    FWD_MALU = 2'd2,
    FWD_MMO  = 2'd3
  } fwd_sel_e;

  // A live producer writes a real register that matches the consumer's source.
  function automatic logic producer_hit(input logic              wr_en,
                                        input logic [REG_AW-1:0] dst,
                                        input logic [REG_AW-1:0] src);
    return wr_en && (dst != R0) && (dst == src);
  endfunction

endpackage

// File: rtl/pipe_regfile32.sv
// 32x32 general register file: async active-low clear, one write port,
// two combinational read ports with write-to-read bypass; r0 reads zero.
module pipe_regfile32
  import pipe_wb_regfile_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_wa,
  input  logic [DATA_W-1:0] i_wd,
  input  logic [REG_AW-1:0] i_ra,
  input  logic [REG_AW-1:0] i_rb,
  output logic [DATA_W-1:0] o_qa,
  output logic [DATA_W-1:0] o_qb
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  // i_we already excludes r0, so entry 0 only ever holds its reset value.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (i_we) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  always_comb begin
    o_qa = r_regs[i_ra];
    if (i_ra == R0)
      o_qa = '0;
    else if (i_we && (i_wa == i_ra))
      o_qa = i_wd;
  end

  always_comb begin
    o_qb = r_regs[i_rb];
    if (i_rb == R0)
      o_qb = '0;
    else if (i_we && (i_wa == i_rb))
      o_qb = i_wd;
  end

endmodule

// File: rtl/pipe_wb_regfile.sv
// Writeback stage merged with the register file, ID-stage operand forwarding,
// load-use stall detection and a committed-write debug counter.
module pipe_wb_regfile
  import pipe_wb_regfile_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              wwreg,
  input  logic              wm2reg,
  input  logic [DATA_W-1:0] wmo,
  input  logic [DATA_W-1:0] walu,
  input  logic [REG_AW-1:0] wrn,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic              ewreg,
  input  logic              em2reg,
  input  logic [REG_AW-1:0] ern,
  input  logic              mwreg,
  input  logic              mm2reg,
  input  logic [REG_AW-1:0] mrn,
  output logic [DATA_W-1:0] qa,
  output logic [DATA_W-1:0] qb,
  output logic [DATA_W-1:0] wdi,
  output logic [1:0]        fwda,
  output logic [1:0]        fwdb,
  output logic              stall,
  output logic [DATA_W-1:0] wbcount
);

  logic              w_commit;
  logic [DATA_W-1:0] r_wbcount;
  fwd_sel_e          w_fwda;
  fwd_sel_e          w_fwdb;

  assign wdi      = wm2reg ? wmo : walu;
  assign w_commit = wwreg && (wrn != R0);

  pipe_regfile32 u_regfile (
    .clock  (clock),
    .resetn (resetn),
    .i_we   (w_commit),
    .i_wa   (wrn),
    .i_wd   (wdi),
    .i_ra   (rs),
    .i_rb   (rt),
    .o_qa   (qa),
    .o_qb   (qb)
  );

  // E beats M; an E-stage load has no ALU result yet, so it never forwards.
  function automatic fwd_sel_e fwd_for(input logic [REG_AW-1:0] src);
    if (producer_hit(ewreg && !em2reg, ern, src))
      return FWD_EALU;
    else if (producer_hit(mwreg, mrn, src))
      return mm2reg ? FWD_MMO : FWD_MALU;
    else
      return FWD_REG;
  endfunction

  assign w_fwda = fwd_for(rs);
  assign w_fwdb = fwd_for(rt);
  assign fwda   = w_fwda;
  assign fwdb   = w_fwdb;

  assign stall = producer_hit(ewreg && em2reg, ern, rs) ||
                 producer_hit(ewreg && em2reg, ern, rt);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      r_wbcount <= '0;
    else if (w_commit)
      r_wbcount <= r_wbcount + 32'd1;
  end

  assign wbcount = r_wbcount;

endmodule

// File: tb/tb_pipe_wb_regfile.sv
// Self-checking bench for pipe_wb_regfile: directed steps plus a randomized
// run compared against an array-based reference of the register file.
module tb_pipe_wb_regfile;

  logic        clock = 1'b0;
  logic        resetn;
  logic        wwreg, wm2reg;
  logic [31:0] wmo, walu;
  logic [4:0]  wrn, rs, rt;
  logic        ewreg, em2reg, mwreg, mm2reg;
  logic [4:0]  ern, mrn;
  logic [31:0] qa, qb, wdi, wbcount;
  logic [1:0]  fwda, fwdb;
  logic        stall;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;

  pipe_wb_regfile dut (
    .clock(clock), .resetn(resetn),
    .wwreg(wwreg), .wm2reg(wm2reg), .wmo(wmo), .walu(walu), .wrn(wrn),
    .rs(rs), .rt(rt),
    .ewreg(ewreg), .em2reg(em2reg), .ern(ern),
    .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn),
    .qa(qa), .qb(qb), .wdi(wdi), .fwda(fwda), .fwdb(fwdb),
    .stall(stall), .wbcount(wbcount)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_wdi();
    return wm2reg ? wmo : walu;
  endfunction

  function automatic logic m_commits();
    return wwreg && (wrn != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (m_commits() && wrn == r) return m_wdi();
    return m_regs[r];
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] r);
    if (ewreg && !em2reg && ern != 5'd0 && ern == r) return 2'd1;
    if (mwreg && mrn != 5'd0 && mrn == r) return mm2reg ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  function automatic logic m_stall();
    return ewreg && em2reg && ern != 5'd0 && (ern == rs || ern == rt);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_cnt = 32'd0;
  endtask

  task automatic idle();
    wwreg = 0; wm2reg = 0; wmo = 0; walu = 0; wrn = 0;
    ewreg = 0; em2reg = 0; ern = 0; mwreg = 0; mm2reg = 0; mrn = 0;
  endtask

  task automatic check_comb(input string tag);
    #1;
    chk({tag, ".wdi"},   wdi,   m_wdi());
    chk({tag, ".qa"},    qa,    m_read(rs));
    chk({tag, ".qb"},    qb,    m_read(rt));
    chk({tag, ".fwda"},  {30'd0, fwda},  {30'd0, m_fwd(rs)});
    chk({tag, ".fwdb"},  {30'd0, fwdb},  {30'd0, m_fwd(rt)});
    chk({tag, ".stall"}, {31'd0, stall}, {31'd0, m_stall()});
  endtask

  // Advance one clock; model commits at the edge, wbcount sampled at negedge.
  task automatic tick(input string tag);
    logic        c;
    logic [31:0] d;
    c = m_commits() && resetn;
    d = m_wdi();
    @(posedge clock);
    if (c) begin
      m_regs[wrn] = d;
      m_cnt = m_cnt + 32'd1;
    end
    @(negedge clock);
    chk({tag, ".wbcount"}, wbcount, m_cnt);
  endtask

  initial begin
    idle();
    rs = 5; rt = 31;
    resetn = 0;
    m_clear();
    repeat (2) @(negedge clock);
    resetn = 1;
    check_comb("reset");
    chk("reset.wbcount", wbcount, 32'd0);

    // Commit with same-cycle bypass
    wwreg = 1; wm2reg = 0; walu = 32'h12345678; wrn = 7; rs = 7;
    check_comb("bypass");
    chk("bypass.qa_const", qa, 32'h12345678);
    tick("commit");
    wwreg = 0; walu = 0;
    check_comb("after_commit");
    chk("after_commit.qa_const", qa, 32'h12345678);
    chk("after_commit.cnt_const", wbcount, 32'd1);

    // Memory select, then r0 drop
    wwreg = 1; wm2reg = 1; wmo = 32'hDEADBEEF; wrn = 3; rt = 3;
    check_comb("memsel");
    tick("memsel");
    wwreg = 0;
    check_comb("memsel_read");
    chk("memsel.qb_const", qb, 32'hDEADBEEF);
    wwreg = 1; wm2reg = 0; walu = 32'hFFFFFFFF; wrn = 0; rs = 0;
    check_comb("r0_write");
    tick("r0_write");
    chk("r0.cnt_const", wbcount, 32'd2);
    wwreg = 0;
    check_comb("r0_read");

    // Forwarding priority
    idle(); rs = 4; rt = 4;
    ewreg = 1; mwreg = 1; ern = 4; mrn = 4; em2reg = 0;
    check_comb("fwd_e");
    chk("fwd_e.const", {30'd0, fwda}, 32'd1);
    ewreg = 0; mm2reg = 1;
    check_comb("fwd_mmo");
    chk("fwd_mmo.const", {30'd0, fwda}, 32'd3);
    mm2reg = 0;
    check_comb("fwd_malu");
    chk("fwd_malu.const", {30'd0, fwda}, 32'd2);

    // Load-use stall
    idle(); rs = 1; rt = 9;
    ewreg = 1; em2reg = 1; ern = 9;
    check_comb("stall");
    chk("stall.const", {31'd0, stall}, 32'd1);
    ern = 0; rt = 0;
    check_comb("stall_r0");
    chk("stall_r0.const", {31'd0, stall}, 32'd0);

    // Simultaneous W commit and M match on the same register
    idle(); rs = 12; rt = 12;
    wwreg = 1; walu = 32'hA5A5A5A5; wrn = 12; mwreg = 1; mrn = 12;
    check_comb("w_and_m");
    tick("w_and_m");

    // Randomized run with register numbers biased toward collisions
    for (int n = 0; n < 400; n++) begin
      wwreg  = $urandom_range(0, 1);
      wm2reg = $urandom_range(0, 1);
      wmo    = $urandom;
      walu   = $urandom;
      wrn    = 5'($urandom_range(0, 7));
      rs     = 5'($urandom_range(0, 7));
      rt     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      ewreg  = $urandom_range(0, 1);
      em2reg = $urandom_range(0, 1);
      ern    = 5'($urandom_range(0, 7));
      mwreg  = $urandom_range(0, 1);
      mm2reg = $urandom_range(0, 1);
      mrn    = 5'($urandom_range(0, 7));
      check_comb("rand");
      tick("rand");
    end

    // Reset asserted mid-write
    idle(); rs = 6; rt = 2;
    wwreg = 1; walu = 32'h0BADF00D; wrn = 6;
    #1 resetn = 0;
    m_clear();
    @(posedge clock);
    @(negedge clock);
    chk("rst_mid.wbcount", wbcount, 32'd0);
    wwreg = 0;
    check_comb("rst_mid");
    resetn = 1;
    check_comb("rst_release");

    // Counter wrap
    force dut.r_wbcount = 32'hFFFFFFFF;
    #1 release dut.r_wbcount;
    m_cnt = 32'hFFFFFFFF;
    wwreg = 1; walu = 32'h00C0FFEE; wrn = 17;
    check_comb("wrap");
    tick("wrap");
    chk("wrap.const", wbcount, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
